// File: rtl/rf_wb_arbiter_if.sv
// Write-back bundle between the two requesters, issue logic,
// the arbiter and the register file write port.
interface rf_wb_arbiter_if;
    logic        a_valid;
    logic [4:0]  a_rw;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_rw;
    logic [31:0] b_data;
    logic        b_ready;
    logic        rsv_valid;
    logic [4:0]  rsv_rd;
    logic        regwr;
    logic [4:0]  rw;
    logic [31:0] busW;
    logic [31:0] busy;

    modport slave (
        input  a_valid, a_rw, a_data,
        input  b_valid, b_rw, b_data,
        input  rsv_valid, rsv_rd,
        output a_ready, b_ready,
        output regwr, rw, busW, busy
    );

    modport master (
        output a_valid, a_rw, a_data,
        output b_valid, b_rw, b_data,
        output rsv_valid, rsv_rd,
        input  a_ready, b_ready,
        input  regwr, rw, busW, busy
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter for the register file write port,
// with a per-register busy scoreboard for issue stalls.
module rf_wb_arbiter (
    input  logic           wrclk,
    input  logic           rst_n,
    rf_wb_arbiter_if.slave wb
);

    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } grant_e;

    grant_e      last_grant;
    logic        xfer;
    logic [4:0]  req_rw;
    logic [31:0] req_data;
    logic        regwr_q;
    logic [4:0]  rw_q;
    logic [31:0] busw_q;
    logic [31:0] busy_q;
    logic [31:0] busy_d;

    // Ready depends only on valids and last_grant, never on rw/data.
    assign wb.a_ready = wb.a_valid &&
                        (!wb.b_valid || last_grant == GNT_B);
    assign wb.b_ready = wb.b_valid &&
                        (!wb.a_valid || last_grant == GNT_A);

    assign xfer     = wb.a_ready || wb.b_ready;
    assign req_rw   = wb.a_ready ? wb.a_rw   : wb.b_rw;
    assign req_data = wb.a_ready ? wb.a_data : wb.b_data;

    always_comb begin
        busy_d = busy_q;
        if (regwr_q)
            busy_d[rw_q] = 1'b0;
        // Reservation after the clear so a same-cycle set wins.
        if (wb.rsv_valid && wb.rsv_rd != 5'd0)
            busy_d[wb.rsv_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge wrclk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= GNT_B;
            regwr_q    <= 1'b0;
            rw_q       <= 5'd0;
            busw_q     <= 32'd0;
            busy_q     <= 32'd0;
        end else begin
            busy_q  <= busy_d;
            regwr_q <= xfer && req_rw != 5'd0;
            if (xfer) begin
                rw_q   <= req_rw;
                busw_q <= req_data;
            end
            if (wb.a_ready)
                last_grant <= GNT_A;
            else if (wb.b_ready)
                last_grant <= GNT_B;
        end
    end

    assign wb.regwr = regwr_q;
    assign wb.rw    = rw_q;
    assign wb.busW  = busw_q;
    assign wb.busy  = busy_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed-vector bench for rf_wb_arbiter: handshake, round-robin,
// issue timing, r0 handling, scoreboard and asynchronous reset.
module tb_rf_wb_arbiter;

    logic wrclk;
    logic rst_n;
    int   vecs;
    int   errs;
    logic [31:0] rf [32];

    rf_wb_arbiter_if wb ();

    rf_wb_arbiter dut (
        .wrclk (wrclk),
        .rst_n (rst_n),
        .wb    (wb.slave)
    );

    initial wrclk = 1'b0;
    always #5 wrclk = ~wrclk;

    // Stand-in for the register file sitting on the write port.
    always @(posedge wrclk)
        if (wb.regwr)
            rf[wb.rw] <= wb.busW;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        vecs++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wrclk);
        #1;
    endtask

    task automatic idle();
        wb.a_valid   = 1'b0;
        wb.b_valid   = 1'b0;
        wb.rsv_valid = 1'b0;
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        rst_n = 1'b0;
        idle();
        wb.a_rw   = 5'd0;
        wb.a_data = 32'd0;
        wb.b_rw   = 5'd0;
        wb.b_data = 32'd0;
        wb.rsv_rd = 5'd0;
        tick();
        tick();
        rst_n = 1'b1;
        #2;
        check("rst_regwr", {31'd0, wb.regwr}, 32'd0);
        check("rst_rw", {27'd0, wb.rw}, 32'd0);
        check("rst_busw", wb.busW, 32'd0);
        check("rst_busy", wb.busy, 32'd0);

        // Single requester A
        tick();
        wb.a_valid = 1'b1;
        wb.a_rw    = 5'd5;
        wb.a_data  = 32'hDEADBEEF;
        #2;
        check("single_ardy", {31'd0, wb.a_ready}, 32'd1);
        check("single_brdy", {31'd0, wb.b_ready}, 32'd0);
        tick();
        idle();
        #2;
        check("single_regwr", {31'd0, wb.regwr}, 32'd1);
        check("single_rw", {27'd0, wb.rw}, 32'd5);
        check("single_busw", wb.busW, 32'hDEADBEEF);
        check("idle_ardy", {31'd0, wb.a_ready}, 32'd0);
        tick();
        check("single_off", {31'd0, wb.regwr}, 32'd0);
        check("single_rf5", rf[5], 32'hDEADBEEF);

        // Scoreboard: reserve r7, then B writes r7
        wb.rsv_valid = 1'b1;
        wb.rsv_rd    = 5'd7;
        tick();
        idle();
        #2;
        check("sb_set", wb.busy, 32'h0000_0080);
        wb.b_valid = 1'b1;
        wb.b_rw    = 5'd7;
        wb.b_data  = 32'd77;
        #2;
        check("sb_brdy", {31'd0, wb.b_ready}, 32'd1);
        tick();
        idle();
        #2;
        check("sb_wr_regwr", {31'd0, wb.regwr}, 32'd1);
        check("sb_wr_busy", wb.busy, 32'h0000_0080);
        tick();
        check("sb_clr", wb.busy, 32'd0);
        check("sb_rf7", rf[7], 32'd77);

        // Set and clear of r7 on the same edge: set wins
        wb.rsv_valid = 1'b1;
        wb.rsv_rd    = 5'd7;
        tick();
        idle();
        wb.b_valid = 1'b1;
        wb.b_data  = 32'd78;
        tick();
        idle();
        wb.rsv_valid = 1'b1;
        wb.rsv_rd    = 5'd7;
        #2;
        check("sb_race_regwr", {31'd0, wb.regwr}, 32'd1);
        tick();
        idle();
        #2;
        check("sb_race_busy", wb.busy, 32'h0000_0080);

        // r0: accepted but never written, never busy
        wb.a_valid   = 1'b1;
        wb.a_rw      = 5'd0;
        wb.a_data    = 32'h55;
        wb.rsv_valid = 1'b1;
        wb.rsv_rd    = 5'd0;
        #2;
        check("r0_ardy", {31'd0, wb.a_ready}, 32'd1);
        tick();
        idle();
        #2;
        check("r0_regwr", {31'd0, wb.regwr}, 32'd0);
        check("r0_busy", wb.busy, 32'h0000_0080);
        tick();
        check("r0_rf0", rf[0], 32'd0);

        // Back-to-back same destination, A then B
        wb.a_valid = 1'b1;
        wb.a_rw    = 5'd3;
        wb.a_data  = 32'd10;
        #2;
        check("b2b_ardy", {31'd0, wb.a_ready}, 32'd1);
        tick();
        idle();
        wb.b_valid = 1'b1;
        wb.b_rw    = 5'd3;
        wb.b_data  = 32'd20;
        #2;
        check("b2b_brdy", {31'd0, wb.b_ready}, 32'd1);
        check("b2b_w1_regwr", {31'd0, wb.regwr}, 32'd1);
        check("b2b_w1_busw", wb.busW, 32'd10);
        tick();
        idle();
        #2;
        check("b2b_w2_regwr", {31'd0, wb.regwr}, 32'd1);
        check("b2b_w2_busw", wb.busW, 32'd20);
        tick();
        check("b2b_off", {31'd0, wb.regwr}, 32'd0);
        check("b2b_rf3", rf[3], 32'd20);

        // Reset with a write pending on the port
        wb.rsv_valid = 1'b1;
        wb.rsv_rd    = 5'd9;
        wb.a_valid   = 1'b1;
        wb.a_rw      = 5'd9;
        wb.a_data    = 32'd99;
        tick();
        idle();
        #1;
        rst_n = 1'b0;
        #1;
        check("mrst_regwr", {31'd0, wb.regwr}, 32'd0);
        check("mrst_rw", {27'd0, wb.rw}, 32'd0);
        check("mrst_busw", wb.busW, 32'd0);
        check("mrst_busy", wb.busy, 32'd0);
        tick();
        check("mrst_rf9", rf[9], 32'd0);
        rst_n = 1'b1;

        // Contention: A first, then alternate
        wb.a_valid = 1'b1;
        wb.a_rw    = 5'd1;
        wb.a_data  = 32'd1;
        wb.b_valid = 1'b1;
        wb.b_rw    = 5'd2;
        wb.b_data  = 32'd2;
        for (int i = 0; i < 4; i++) begin
            #2;
            check($sformatf("cont_ardy%0d", i),
                  {31'd0, wb.a_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("cont_brdy%0d", i),
                  {31'd0, wb.b_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
            if (i > 0) begin
                check($sformatf("cont_regwr%0d", i),
                      {31'd0, wb.regwr}, 32'd1);
                check($sformatf("cont_busw%0d", i),
                      wb.busW, (i % 2 == 1) ? 32'd1 : 32'd2);
            end
            tick();
        end
        idle();
        #2;
        check("cont_regwr4", {31'd0, wb.regwr}, 32'd1);
        check("cont_busw4", wb.busW, 32'd2);
        tick();
        check("cont_off", {31'd0, wb.regwr}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter and scoreboard for the 32×32 register file. It shares the file's single write port (regwr/rw/busW) between two write-back requesters, A (ALU) and B (load unit), using a round-robin valid/ready handshake. It also keeps a per-register busy scoreboard so issue logic can stall on pending writes. It sits between the execute/memory stages and the register file, on the register file's write clock.

## Interface
Parameters: none (widths fixed at 5-bit register index, 32-bit data).

Ports:
- wrclk  in  1  clock; the register file's write clock, all state on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- a_valid  in  1  requester A has a write-back pending
- a_rw  in  5  A destination register
- a_data  in  32  A write data
- a_ready  out  1  A request accepted this cycle (combinational)
- b_valid  in  1  requester B has a write-back pending
- b_rw  in  5  B destination register
- b_data  in  32  B write data
- b_ready  out  1  B request accepted this cycle (combinational)
- rsv_valid  in  1  issue logic reserves a destination register this cycle
- rsv_rd  in  5  register being reserved
- regwr  out  1  register file write enable (registered)
- rw  out  5  register file write index (registered)
- busW  out  32  register file write data (registered)
- busy  out  32  scoreboard; bit i = write to register i outstanding (registered)

## Operation
- Handshake: a request transfers when valid && ready on the same edge. The requester holds valid/rw/data stable until ready. ready never asserts without valid.
- Arbitration: round-robin via a 1-bit last_grant register.
  - Only one requester valid: it is granted.
  - Both valid: the requester that was not last granted wins.
  - last_grant updates only on an actual transfer.
- At most one transfer per cycle. a_ready and b_ready are never both 1.
- Issue stage: on transfer, regwr/rw/busW load next edge as 1/req_rw/req_data.
  - With no transfer, regwr loads 0; rw and busW hold.
- Register 0: a request with rw=0 is still accepted (ready=1) but regwr loads 0. r0 is never written.
- Same destination from A and B in consecutive grants: both writes issue in grant order; the later grant's data ends up in the file.
- Scoreboard:
  - rsv_valid && rsv_rd≠0 sets busy[rsv_rd] on the edge.
  - busy[rw] clears on the edge ending a cycle where regwr=1.
  - Simultaneous set and clear of the same bit: set wins.
  - busy[0] is constant 0.
  - A write-back to a non-busy register is legal and leaves busy unchanged.
- Reset (asynchronous, mid-operation included): regwr=0, rw=0, busW=0, busy=0, last_grant=B (so A wins the first contested cycle). A write registered but not yet performed is dropped; its busy bit is cleared.

## Timing
- Request accepted at edge N: regwr=1 throughout cycle N+1. Register file captures at edge N+1.
- The busy bit clears at the same edge N+1, so a reader seeing busy[i]=0 always reads the updated value.
- Throughput: one write-back per cycle sustained. Contested requesters alternate each cycle.
- Latency valid→ready: 0 cycles when uncontested, at most 1 extra cycle under contention (round-robin bound).
- a_ready/b_ready: combinational from a_valid, b_valid, last_grant only. No path from data or rw.
- Outputs regwr/rw/busW/busy: come only from flops.

## Test plan
- Reset: hold rst_n=0 mid-stream with a pending write, then release → regwr=0, rw=0, busW=0, busy=0; the next cycle with a_valid=b_valid=1 grants A first.
- Single requester: a_valid=1, a_rw=5, a_data=32'hDEADBEEF at edge N → a_ready=1 in cycle N; in cycle N+1 regwr=1, rw=5, busW=DEADBEEF; regwr=0 in N+2.
- Contention: A and B valid continuously for 4 cycles (A rw=1,data=1; B rw=2,data=2) → grants alternate A,B,A,B; regwr stays high; busW sequence is 1,2,1,2.
- Scoreboard:
  - rsv_valid=1, rsv_rd=7 → busy[7]=1 next cycle.
  - B writes rw=7 → busy[7] clears at the same edge regwr=1 performs the write.
  - A reservation of r7 in that same cycle keeps busy[7]=1.
- r0 handling: a_rw=0 and rsv_rd=0 → a_ready=1, regwr stays 0, busy stays 0.
- Back-to-back same destination: A rw=3 data=10, then B rw=3 data=20 → regwr high two consecutive cycles, busW 10 then 20; the register file holds 20.
